// File: rtl/counter_seq_pkg.sv
`default_nettype none
// ============================================================================
// counter_seq_pkg : shared state encoding and default width for counter_seq_ctrl
// Revision: 1.0
// ============================================================================
package counter_seq_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_RUN   = ST_RUN,
    S_PAUSE = ST_PAUSE,
    S_DONE  = ST_DONE
  } state_t;

endpackage
`default_nettype wire

// File: rtl/counter_core.sv
`default_nettype none
// ============================================================================
// counter_core : loadable modulo-2^WIDTH up/down counter with terminal compare
// Revision: 1.0
// ============================================================================
module counter_core
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             en,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] Z,
  output logic             eq
);

  logic [WIDTH-1:0] z_q;
  logic [WIDTH-1:0] z_d;

  always_comb begin
    z_d = z_q;
    if (load) begin
      z_d = load_data;
    end else if (en) begin
      z_d = up_dn ? (z_q + 1'b1) : (z_q - 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      z_q <= '0;
    end else begin
      z_q <= z_d;
    end
  end

  assign Z  = z_q;
  assign eq = (z_q == term);

endmodule
`default_nettype wire

// File: rtl/counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// counter_seq_ctrl : command FSM, capture registers and tc pulse around counter_core
// Revision: 1.0
// ============================================================================
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode_reload,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] term_val,
  output logic [WIDTH-1:0] Z,
  output logic             busy,
  output logic             done,
  output logic             tc_pulse
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] load_q, load_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic             dir_q, dir_d;
  logic             reload_q, reload_d;
  logic             tc_q, tc_d;

  logic             w_load;
  logic [WIDTH-1:0] w_load_data;
  logic             w_en;
  logic             w_eq;

  // Command priority: stop > start > pause > terminal check > count
  always_comb begin
    state_d     = state_q;
    load_d      = load_q;
    term_d      = term_q;
    dir_d       = dir_q;
    reload_d    = reload_q;
    tc_d        = 1'b0;
    w_load      = 1'b0;
    w_load_data = load_q;
    w_en        = 1'b0;

    if (stop) begin
      state_d = S_IDLE;
    end else if (start) begin
      load_d      = load_val;
      term_d      = term_val;
      dir_d       = up_dn;
      reload_d    = mode_reload;
      w_load      = 1'b1;
      w_load_data = load_val;
      state_d     = S_RUN;
    end else begin
      case (state_q)
        S_RUN: begin
          if (pause) begin
            state_d = S_PAUSE;
          end else if (w_eq) begin
            tc_d = 1'b1;
            if (reload_q) begin
              w_load = 1'b1;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            w_en = 1'b1;
          end
        end
        S_PAUSE: begin
          if (!pause) begin
            state_d = S_RUN;
          end
        end
        S_IDLE:  state_d = S_IDLE;
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      load_q   <= '0;
      term_q   <= '0;
      dir_q    <= 1'b0;
      reload_q <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      load_q   <= load_d;
      term_q   <= term_d;
      dir_q    <= dir_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  counter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_data(w_load_data),
    .en       (w_en),
    .up_dn    (dir_q),
    .term     (term_q),
    .Z        (Z),
    .eq       (w_eq)
  );

  assign busy     = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign done     = (state_q == S_DONE);
  assign tc_pulse = tc_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_counter_seq_ctrl : vector table plus scoreboard bench for counter_seq_ctrl
// Revision: 1.0
// ============================================================================
module tb_counter_seq_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, start, stop, pause, mode_reload, up_dn;
  logic [W-1:0] load_val, term_val;
  logic [W-1:0] Z;
  logic         busy, done, tc_pulse;

  always #5 clk = ~clk;

  counter_seq_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .mode_reload(mode_reload),
    .up_dn      (up_dn),
    .load_val   (load_val),
    .term_val   (term_val),
    .Z          (Z),
    .busy       (busy),
    .done       (done),
    .tc_pulse   (tc_pulse)
  );

  typedef struct {
    logic         r, s, sp, p, m, u;
    logic [W-1:0] lv, tv, ez;
    logic         eb, ed, et;
  } vec_t;

  typedef struct {
    int           idx;
    logic [W-1:0] z;
    logic         b, d, t;
  } exp_t;

  vec_t         vecs[$];
  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic         cfg_m, cfg_u;
  logic [W-1:0] cfg_lv, cfg_tv;

  task automatic cfg(input logic [W-1:0] lv, input logic [W-1:0] tv, input logic u, input logic m);
    cfg_lv = lv; cfg_tv = tv; cfg_u = u; cfg_m = m;
  endtask

  // r, start, stop, pause -> expected Z, busy, done, tc_pulse after the edge
  task automatic add(input logic r, input logic s, input logic sp, input logic p,
                     input logic [W-1:0] ez, input logic eb, input logic ed, input logic et);
    vec_t v;
    v.r = r; v.s = s; v.sp = sp; v.p = p; v.m = cfg_m; v.u = cfg_u;
    v.lv = cfg_lv; v.tv = cfg_tv; v.ez = ez; v.eb = eb; v.ed = ed; v.et = et;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic sp, input logic p);
    rst = r; start = s; stop = sp; pause = p;
    mode_reload = cfg_m; up_dn = cfg_u; load_val = cfg_lv; term_val = cfg_tv;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   tc_cnt;
    logic busy_ok;

    cfg(0, 0, 0, 0);
    drive(1, 0, 0, 0);

    // reset and idle
    add(1,0,0,0, 0,0,0,0);
    add(1,0,0,0, 0,0,0,0);
    add(0,0,0,0, 0,0,0,0);
    add(0,0,0,0, 0,0,0,0);
    // one-shot up 2..5; inputs changed after capture must be ignored
    cfg(2, 5, 1, 0);
    add(0,1,0,0, 2,1,0,0);
    cfg(9, 1, 0, 1);
    add(0,0,0,0, 3,1,0,0);
    add(0,0,0,0, 4,1,0,0);
    add(0,0,0,0, 5,1,0,0);
    add(0,0,0,0, 5,0,1,1);
    add(0,0,0,0, 5,0,1,0);
    add(0,0,0,0, 5,0,1,0);
    add(0,0,1,0, 5,0,0,0);
    // auto-reload down with wrap 1,0,15,14
    cfg(1, 14, 0, 1);
    add(0,1,0,0, 1,1,0,0);
    add(0,0,0,0, 0,1,0,0);
    add(0,0,0,0, 15,1,0,0);
    add(0,0,0,0, 14,1,0,0);
    add(0,0,0,0, 1,1,0,1);
    add(0,0,0,0, 0,1,0,0);
    add(0,0,0,0, 15,1,0,0);
    add(0,0,0,0, 14,1,0,0);
    add(0,0,0,0, 1,1,0,1);
    add(0,0,1,0, 1,0,0,0);
    // pause at Z=4 for three cycles
    cfg(0, 9, 1, 0);
    add(0,1,0,0, 0,1,0,0);
    add(0,0,0,0, 1,1,0,0);
    add(0,0,0,0, 2,1,0,0);
    add(0,0,0,0, 3,1,0,0);
    add(0,0,0,0, 4,1,0,0);
    add(0,0,0,1, 4,1,0,0);
    add(0,0,0,1, 4,1,0,0);
    add(0,0,0,1, 4,1,0,0);
    add(0,0,0,0, 4,1,0,0);
    add(0,0,0,0, 5,1,0,0);
    add(0,0,0,0, 6,1,0,0);
    add(0,0,0,0, 7,1,0,0);
    add(0,0,0,0, 8,1,0,0);
    add(0,0,0,0, 9,1,0,0);
    add(0,0,0,0, 9,0,1,1);
    add(0,0,1,0, 9,0,0,0);
    // start+pause in IDLE, then start+stop in RUN
    cfg(6, 10, 1, 0);
    add(0,1,0,1, 6,1,0,0);
    add(0,0,0,0, 7,1,0,0);
    cfg(12, 10, 1, 0);
    add(0,1,1,0, 7,0,0,0);
    add(0,0,0,0, 7,0,0,0);
    // reset mid-run at Z=7
    cfg(6, 10, 1, 0);
    add(0,1,0,0, 6,1,0,0);
    add(0,0,0,0, 7,1,0,0);
    add(1,0,0,0, 0,0,0,0);
    add(0,0,0,0, 0,0,0,0);
    // load==term one-shot
    cfg(3, 3, 1, 0);
    add(0,1,0,0, 3,1,0,0);
    add(0,0,0,0, 3,0,1,1);
    add(0,0,0,0, 3,0,1,0);
    // load==term reload from DONE; pause at terminal suppresses tc; stop in PAUSE
    cfg(8, 8, 0, 1);
    add(0,1,0,0, 8,1,0,0);
    add(0,0,0,0, 8,1,0,1);
    add(0,0,0,0, 8,1,0,1);
    add(0,0,0,1, 8,1,0,0);
    add(0,0,1,1, 8,0,0,0);
    // up wrap 14,15,0,1
    cfg(14, 1, 1, 0);
    add(0,1,0,0, 14,1,0,0);
    add(0,0,0,0, 15,1,0,0);
    add(0,0,0,0, 0,1,0,0);
    add(0,0,0,0, 1,1,0,0);
    add(0,0,0,0, 1,0,1,1);
    add(0,0,1,0, 1,0,0,0);
    add(0,0,0,1, 1,0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].r; start = vecs[i].s; stop = vecs[i].sp; pause = vecs[i].p;
      mode_reload = vecs[i].m; up_dn = vecs[i].u;
      load_val = vecs[i].lv; term_val = vecs[i].tv;
      e.idx = i; e.z = vecs[i].ez; e.b = vecs[i].eb; e.d = vecs[i].ed; e.t = vecs[i].et;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard step %0d: got empty queue expected entry", i);
      end else begin
        e = sb.pop_front();
        chk("Z", e.idx, int'(Z), int'(e.z));
        chk("busy", e.idx, int'(busy), int'(e.b));
        chk("done", e.idx, int'(done), int'(e.d));
        chk("tc_pulse", e.idx, int'(tc_pulse), int'(e.t));
      end
    end

    // long auto-reload run: tc every 4th edge, busy never drops
    cfg(1, 14, 0, 1);
    @(negedge clk);
    drive(0, 1, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0);
    tc_cnt  = 0;
    busy_ok = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (tc_pulse) tc_cnt++;
      if (!busy) busy_ok = 1'b0;
    end
    chk("reload_tc_count", 1000, tc_cnt, 3);
    chk("reload_busy_held", 1000, int'(busy_ok), 1);
    chk("reload_final_Z", 1000, int'(Z), 1);
    @(negedge clk);
    drive(0, 0, 1, 0);
    @(posedge clk);
    #1;
    chk("stop_busy", 1001, int'(busy), 0);
    chk("stop_Z", 1001, int'(Z), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
